// File: rtl/vram_copy_arbiter.sv
// ---------------------------------------------------------------------------
// vram_copy_arbiter
//
// Purpose:
//   Copies the image ROM into video RAM after power-up (or on request), one
//   word at a time, and shares the single VRAM port with the video scan-out
//   reader. Video reads always own the port. The copy writes only on cycles
//   where no video read is requested, and otherwise stalls with its word held.
//
// Ports:
//   clk_sys     system/pixel clock, rising-edge logic
//   reset_n     asynchronous active-low reset
//   start       single-cycle pulse, restarts the copy when it has finished
//   rom_addr    registered ROM word address
//   rom_data    ROM word, valid one cycle after rom_addr is registered
//   vid_req     video read request for this cycle
//   vid_addr    video read address
//   vid_data    video read data (VRAM read data passed through)
//   vid_valid   vid_req delayed by one cycle, qualifies vid_data
//   vram_addr   VRAM address (combinational port mux)
//   vram_wdata  VRAM write data (the held word buffer)
//   vram_we     VRAM write enable, never high together with vid_req
//   vram_rdata  VRAM read data, one-cycle latency
//   progress    high while a copy is running
//   done        high once a copy has completed, cleared by a restart
// ---------------------------------------------------------------------------
module vram_copy_arbiter #(
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 8,
    parameter int IMG_WORDS = 16000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_wdata,
    output logic              vram_we,
    input  logic [DATA_W-1:0] vram_rdata,
    output logic              progress,
    output logic              done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WORDS - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [DATA_W-1:0] wbuf;
    logic              pending;

    // The copy may commit its write only in WRITE and only when video is idle.
    logic copy_write;
    assign copy_write = (state == ST_WRITE) && !vid_req;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            wbuf      <= '0;
            rom_addr  <= '0;
            vid_valid <= 1'b0;
            done      <= 1'b0;
            // Leaving reset starts a copy without needing a start pulse.
            pending   <= 1'b1;
        end else begin
            vid_valid <= vid_req;
            case (state)
                ST_IDLE: begin
                    if (pending || start) begin
                        pending <= 1'b0;
                        state   <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    rom_addr <= ptr;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    wbuf  <= rom_data;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    // While video holds the port, wbuf and ptr stay put.
                    if (copy_write) begin
                        if (ptr == LAST_ADDR) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            ptr   <= ptr + ADDR_W'(1);
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        ptr   <= '0;
                        done  <= 1'b0;
                        state <= ST_FETCH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Port mux: video read first, then the copy write, else park on ptr.
    always_comb begin
        vram_addr = ptr;
        vram_we   = 1'b0;
        if (vid_req) begin
            vram_addr = vid_addr;
        end else if (state == ST_WRITE) begin
            vram_we = 1'b1;
        end
    end

    assign vram_wdata = wbuf;
    assign vid_data   = vram_rdata;
    assign progress   = (state == ST_FETCH) || (state == ST_WAIT) ||
                        (state == ST_WRITE);

endmodule

// File: tb/tb_vram_copy_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for vram_copy_arbiter with a 16-word image.
// ROM is combinational from the registered rom_addr; VRAM is a synchronous
// read-old RAM. Expected copy writes (address i gets ROM[i], in order) and
// expected video read data are queued and checked by a negedge monitor.
// ---------------------------------------------------------------------------
module tb_vram_copy_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int NW     = 16;

    logic              clk_sys = 1'b0;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_data;
    logic              vid_valid;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_wdata;
    logic              vram_we;
    logic [DATA_W-1:0] vram_rdata;
    logic              progress;
    logic              done;

    vram_copy_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .IMG_WORDS(NW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
        .vid_valid(vid_valid), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_we(vram_we), .vram_rdata(vram_rdata),
        .progress(progress), .done(done)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int done_rises = 0;
    logic done_q = 1'b0;
    logic exp_valid;
    logic clr_req;

    logic [DATA_W-1:0] rom  [0:63];
    logic [DATA_W-1:0] vmem [0:63];
    logic [ADDR_W+DATA_W-1:0] wq [$];
    logic [DATA_W-1:0]        rq [$];

    assign rom_data = rom[rom_addr[5:0]];

    // Reference image: word i of the image is i + 0x40.
    function automatic logic [DATA_W-1:0] img(input int i);
        return DATA_W'(i + 'h40);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // VRAM model (read-old synchronous RAM) with a bench-side clear request.
    always @(posedge clk_sys) begin
        if (clr_req) begin
            for (int i = 0; i < 64; i++) vmem[i] <= 8'hEE;
        end else if (vram_we) begin
            vmem[vram_addr[5:0]] <= vram_wdata;
        end
        vram_rdata <= vmem[vram_addr[5:0]];
    end

    // Expected read data is the RAM content at the requested address.
    always @(posedge clk_sys) begin
        if (reset_n && vid_req) rq.push_back(vmem[vid_addr[5:0]]);
    end

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) exp_valid <= 1'b0;
        else          exp_valid <= vid_req;
    end

    // Monitor.
    always @(negedge clk_sys) begin
        done_q <= done;
        if (reset_n) begin
            if (done && !done_q) done_rises++;
            chk("vid_valid", 32'(vid_valid), 32'(exp_valid));
            if (vid_valid) begin
                if (rq.size() == 0) chk("read_underflow", 1, 0);
                else chk("vid_data", 32'(vid_data), 32'(rq.pop_front()));
            end
            if (vram_we) begin
                n_writes++;
                chk("we_while_vid_req", 32'(vid_req), 0);
                if (wq.size() == 0) chk("extra_write", 32'(vram_addr), 32'hFFFF);
                else chk("write_addr_data", 32'({vram_addr, vram_wdata}), 32'(wq.pop_front()));
            end
        end
    end

    task automatic push_copy();
        wq.delete();
        for (int i = 0; i < NW; i++) wq.push_back({ADDR_W'(i), img(i)});
        n_writes = 0;
    endtask

    task automatic clear_vram();
        clr_req = 1'b1;
        @(posedge clk_sys); #1;
        clr_req = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            @(posedge clk_sys); #1;
            c++;
        end
        chk("done_within_budget", 32'(done), 1);
    endtask

    task automatic check_copy(input string tag);
        chk({tag, "_progress_low"}, 32'(progress), 0);
        chk({tag, "_write_count"}, 32'(n_writes), NW);
        chk({tag, "_queue_empty"}, 32'(wq.size()), 0);
        for (int i = 0; i < NW; i++) chk({tag, "_vram"}, 32'(vmem[i]), 32'(img(i)));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 0);
        chk({tag, "_vid_valid"}, 32'(vid_valid), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_progress"}, 32'(progress), 0);
        chk({tag, "_vram_we"}, 32'(vram_we), 0);
        chk({tag, "_vram_addr"}, 32'(vram_addr), 0);
    endtask

    initial begin
        int edge_n;
        int rises0;
        bit found;
        bit start_sent;
        for (int i = 0; i < 64; i++) rom[i] = (i < NW) ? img(i) : DATA_W'($urandom);
        reset_n = 1'b0; start = 1'b0; vid_req = 1'b0; vid_addr = '0; clr_req = 1'b1;
        repeat (2) @(posedge clk_sys);
        #2 clr_req = 1'b0;
        check_reset_values("reset");

        // Power-up copy with no video traffic.
        push_copy();
        @(posedge clk_sys); #3 reset_n = 1'b1;
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        chk("progress_edge2", 32'(progress), 1);
        chk("first_fetch_addr", 32'(rom_addr), 0);
        edge_n = 2;
        while (!done && edge_n < 80) begin
            @(posedge clk_sys); #1;
            edge_n++;
        end
        chk("done_edge", 32'(edge_n), 49);
        check_copy("copy1");

        // Restart from DONE, then stall the write of word 5 for 10 cycles.
        clear_vram();
        push_copy();
        pulse_start();
        chk("restart_done_low", 32'(done), 0);
        chk("restart_progress", 32'(progress), 1);
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(posedge clk_sys); #1;
            if (vram_we && vram_addr == ADDR_W'(5)) found = 1'b1;
        end
        chk("reached_write5", 32'(found), 1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) begin
                @(posedge clk_sys); #1;
            end
            vid_req  = 1'b1;
            vid_addr = ADDR_W'($urandom_range(0, 31));
            #1;
            chk("stall_we_low", 32'(vram_we), 0);
            chk("stall_addr_mux", 32'(vram_addr), 32'(vid_addr));
        end
        @(posedge clk_sys); #1;
        vid_req = 1'b0;
        #1;
        chk("stall_release_we", 32'(vram_we), 1);
        chk("stall_release_addr", 32'(vram_addr), 5);
        chk("stall_release_data", 32'(vram_wdata), 32'(img(5)));
        wait_done(100);
        check_copy("copy2");

        // Random 70% video traffic; a start pulse at word 7 must be ignored.
        clear_vram();
        push_copy();
        rises0 = done_rises;
        pulse_start();
        start_sent = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk_sys); #1;
            start = 1'b0;
            if (done) break;
            vid_req  = ($urandom_range(0, 99) < 70);
            vid_addr = ADDR_W'($urandom_range(0, 31));
            #1;
            if (!start_sent && vram_we && vram_addr == ADDR_W'(7)) begin
                start = 1'b1;
                start_sent = 1'b1;
            end
        end
        vid_req = 1'b0;
        start   = 1'b0;
        chk("random_done", 32'(done), 1);
        chk("midcopy_start_seen", 32'(start_sent), 1);
        repeat (4) @(posedge clk_sys);
        #1;
        chk("single_done_rise", 32'(done_rises - rises0), 1);
        chk("done_held", 32'(done), 1);
        check_copy("copy3");

        // Asynchronous reset mid-copy at word 9.
        clear_vram();
        push_copy();
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            @(posedge clk_sys); #1;
            if (vram_we && vram_addr == ADDR_W'(9)) found = 1'b1;
        end
        chk("reached_write9", 32'(found), 1);
        #3 reset_n = 1'b0;
        #1;
        check_reset_values("midreset");
        push_copy();
        rq.delete();
        repeat (3) @(posedge clk_sys);
        #3 reset_n = 1'b1;
        wait_done(100);
        check_copy("copy4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
